// File: rtl/sensor_conditioner_if.sv
// Detector/light/demand bundle between the loop-detector front end and the traffic controller.
// The master drives raw detectors, lights and the sample strobe; the slave returns conditioned demand.
interface sensor_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             sample_en;
  logic             NS_raw;
  logic             EW_raw;
  logic [2:0]       NS_light;
  logic [2:0]       EW_light;
  logic             NS_sensor;
  logic             EW_sensor;
  logic [CNT_W-1:0] NS_count;
  logic [CNT_W-1:0] EW_count;
  logic             NS_fault;
  logic             EW_fault;

  modport master (
    output sample_en, NS_raw, EW_raw, NS_light, EW_light,
    input  NS_sensor, EW_sensor, NS_count, EW_count, NS_fault, EW_fault
  );

  modport slave (
    input  sample_en, NS_raw, EW_raw, NS_light, EW_light,
    output NS_sensor, EW_sensor, NS_count, EW_count, NS_fault, EW_fault
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Two-channel loop-detector conditioner: synchronise, debounce, count vehicles, flag stuck detectors.
// Optional SENSOR_HOLD_EN latches demand until the direction's own light turns green.
module sensor_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 60,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_conditioner_if.slave  bus
);
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int ST_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       raw_w;
  logic [1:0]       sensor_w;
  logic [1:0]       fault_w;
  logic [CNT_W-1:0] count_w [2];

  assign raw_w = {bus.EW_raw, bus.NS_raw};

`ifdef SENSOR_HOLD_EN
  logic [2:0] light_w [2];
  assign light_w[0] = bus.NS_light;
  assign light_w[1] = bus.EW_light;
`else
  logic lights_unused;
  assign lights_unused = ^{bus.NS_light, bus.EW_light};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
      logic [ST_W-1:0]        st_cnt_q, st_cnt_d;
      logic [CNT_W-1:0]       count_q, count_d;
      logic                   stable_q, stable_d;
      logic                   demand_q, demand_d;
      logic                   fault_q, fault_d;
      logic                   sensor_q, sensor_d;
      logic                   sync_s;

      assign sync_s = sync_q[SYNC_STAGES-1];

      // Outputs are computed from next-state values so they move on the same edge as stable.
      always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_w[gi]};
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        st_cnt_d = st_cnt_q;
        if (bus.sample_en) begin
          if (sync_s == stable_q) begin
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
            stable_d = sync_s;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
          if (!stable_d) begin
            st_cnt_d = '0;
          end else if (st_cnt_q != ST_W'(STUCK_LIMIT)) begin
            st_cnt_d = st_cnt_q + 1'b1;
          end
        end
        count_d = (stable_d && !stable_q && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;
        fault_d = (st_cnt_d == ST_W'(STUCK_LIMIT));
`ifdef SENSOR_HOLD_EN
        demand_d = stable_d | (demand_q & (light_w[gi] != 3'b001));
`else
        demand_d = stable_d;
`endif
        sensor_d = demand_d | fault_d;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q   <= '0;
          db_cnt_q <= '0;
          st_cnt_q <= '0;
          count_q  <= '0;
          stable_q <= 1'b0;
          demand_q <= 1'b0;
          fault_q  <= 1'b0;
          sensor_q <= 1'b0;
        end else begin
          sync_q   <= sync_d;
          db_cnt_q <= db_cnt_d;
          st_cnt_q <= st_cnt_d;
          count_q  <= count_d;
          stable_q <= stable_d;
          demand_q <= demand_d;
          fault_q  <= fault_d;
          sensor_q <= sensor_d;
        end
      end

      assign sensor_w[gi] = sensor_q;
      assign fault_w[gi]  = fault_q;
      assign count_w[gi]  = count_q;
    end
  endgenerate

  assign bus.NS_sensor = sensor_w[0];
  assign bus.EW_sensor = sensor_w[1];
  assign bus.NS_fault  = fault_w[0];
  assign bus.EW_fault  = fault_w[1];
  assign bus.NS_count  = count_w[0];
  assign bus.EW_count  = count_w[1];
endmodule
